// File: rtl/mem_multicycle_if.sv
// Request/response bundle between the cache miss controller and main memory.
interface mem_multicycle_if;
   logic [15:0] addr;
   logic        enable;
   logic        wr;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        data_valid;
   logic        pending;

   modport master (output addr, enable, wr, data_in,
                   input  data_out, data_valid, pending);
   modport slave  (input  addr, enable, wr, data_in,
                   output data_out, data_valid, pending);
endinterface

// File: rtl/mem_multicycle.sv
// Main-memory model: writes commit immediately, reads return LATENCY cycles
// after issue through a free-running valid/data shift register.
module mem_multicycle #(
   parameter int LATENCY    = 4,
   parameter int WORDS_LOG2 = 15
) (
   input  logic            clk,
   input  logic            rst,
   mem_multicycle_if.slave bus
);
   logic [15:0]              mem [0:(1<<WORDS_LOG2)-1];
   logic [LATENCY-1:0]       vld_pipe;
   logic [LATENCY-1:0][15:0] dat_pipe;
   logic [WORDS_LOG2-1:0]    idx;
   logic                     rd;
   logic                     wen;
   logic                     unused_addr;

   // Byte address: bit 0 and bits above the word index are dropped, so addresses alias.
   assign idx         = bus.addr[WORDS_LOG2:1];
   assign unused_addr = ^bus.addr;
   assign rd          = bus.enable & ~bus.wr;
   assign wen         = bus.enable & bus.wr;

   // The array sits in the reset branch's else so a write during rst is dropped;
   // its contents are never cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         dat_pipe <= '0;
      end else begin
         if (wen) mem[idx] <= bus.data_in;
         vld_pipe[0] <= rd;
         dat_pipe[0] <= rd ? mem[idx] : 16'h0000;
         for (int i = 1; i < LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            dat_pipe[i] <= dat_pipe[i-1];
         end
      end
   end

   // Non-read stages carry zero data, so data_out is zero whenever data_valid is low.
   assign bus.data_valid = vld_pipe[LATENCY-1];
   assign bus.data_out   = dat_pipe[LATENCY-1];
   assign bus.pending    = |vld_pipe;
endmodule
